// File: rtl/bcd_pkg.sv
// Shared types and helpers for the digit-serial BCD accumulator.
package bcd_pkg;

    localparam int unsigned BCD_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } bcd_acc_state_t;

    function automatic logic is_bcd(input logic [3:0] nib);
        return nib <= 4'd9;
    endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// Combinational single-digit BCD adder: a + b + cin -> decimal digit and carry.
module bcd_digit_adder
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] a,
    input  logic [BCD_W-1:0] b,
    input  logic             cin,
    output logic [BCD_W-1:0] sum,
    output logic             cout
);

    logic [BCD_W:0] raw;

    always_comb begin
        raw  = {1'b0, a} + {1'b0, b} + {{BCD_W{1'b0}}, cin};
        cout = raw > 5'd9;
        // Adding 6 skips the six unused codes and lands on the decimal digit.
        sum  = cout ? (raw[BCD_W-1:0] + 4'd6) : raw[BCD_W-1:0];
    end

endmodule

// File: rtl/bcd_accumulator.sv
// Accumulates 0..199 adder results into a DIGITS-digit BCD total, one digit per clock,
// with sticky overflow and an invalid-digit pulse.
module bcd_accumulator
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [7:0]              in_sum,
    input  logic                    in_carry,
    input  logic                    clear,
    output logic [BCD_W*DIGITS-1:0] total,
    output logic                    out_valid,
    output logic                    overflow,
    output logic                    bad_digit
);

    localparam int unsigned IDX_W = $clog2(DIGITS);
    localparam int unsigned TOT_W = BCD_W * DIGITS;

    bcd_acc_state_t   state_q;
    logic [IDX_W-1:0] d_q;
    logic [8:0]       add_q;
    logic [TOT_W-1:0] work_q;
    logic [TOT_W-1:0] work_next;
    logic [TOT_W-1:0] total_q;
    logic             c_q;
    logic             overflow_q;
    logic             out_valid_q;
    logic             bad_digit_q;

    logic [BCD_W-1:0] work_dig;
    logic [BCD_W-1:0] add_dig;
    logic [BCD_W-1:0] sum_dig;
    logic             dig_cout;
    logic             hs;
    logic             in_ok;
    logic             last;

    assign in_ready  = (state_q == IDLE) && !clear;
    assign hs        = in_valid && in_ready;
    assign in_ok     = is_bcd(in_sum[3:0]) && is_bcd(in_sum[7:4]);
    assign last      = d_q == IDX_W'(DIGITS - 1);
    assign total     = total_q;
    assign out_valid = out_valid_q;
    assign overflow  = overflow_q;
    assign bad_digit = bad_digit_q;

    // Addend holds only units, tens and the hundreds carry; higher digits read as zero.
    always_comb begin
        add_dig = '0;
        if (d_q == IDX_W'(0)) begin
            add_dig = add_q[3:0];
        end else if (d_q == IDX_W'(1)) begin
            add_dig = add_q[7:4];
        end else if (d_q == IDX_W'(2)) begin
            add_dig = {3'b000, add_q[8]};
        end
    end

    always_comb begin
        work_dig  = work_q[d_q*BCD_W +: BCD_W];
        work_next = work_q;
        work_next[d_q*BCD_W +: BCD_W] = sum_dig;
    end

    bcd_digit_adder u_digit_adder (
        .a    (work_dig),
        .b    (add_dig),
        .cin  (c_q),
        .sum  (sum_dig),
        .cout (dig_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            d_q         <= '0;
            add_q       <= '0;
            work_q      <= '0;
            total_q     <= '0;
            c_q         <= 1'b0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
            bad_digit_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            bad_digit_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (clear) begin
                        total_q    <= '0;
                        overflow_q <= 1'b0;
                    end else if (hs) begin
                        if (in_ok) begin
                            add_q   <= {in_carry, in_sum};
                            work_q  <= total_q;
                            c_q     <= 1'b0;
                            d_q     <= '0;
                            state_q <= ADD;
                        end else begin
                            bad_digit_q <= 1'b1;
                        end
                    end
                end
                ADD: begin
                    work_q <= work_next;
                    c_q    <= dig_cout;
                    d_q    <= d_q + 1'b1;
                    // Commit on the last digit so total and out_valid appear together in DONE.
                    if (last) begin
                        total_q     <= work_next;
                        out_valid_q <= 1'b1;
                        if (dig_cout) begin
                            overflow_q <= 1'b1;
                        end
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_accumulator.sv
// Self-checking bench for bcd_accumulator: integer reference model feeds a commit scoreboard.
module tb_bcd_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_sum;
    logic        in_carry;
    logic        clear;
    logic [15:0] total;
    logic        out_valid;
    logic        overflow;
    logic        bad_digit;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [15:0] total;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];
    int   model_val;
    logic model_ovf;

    bcd_accumulator #(.DIGITS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .in_carry  (in_carry),
        .clear     (clear),
        .total     (total),
        .out_valid (out_valid),
        .overflow  (overflow),
        .bad_digit (bad_digit)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    function automatic logic [15:0] to_bcd(input int v);
        int x;
        logic [15:0] r;
        x = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic push_model(input logic [7:0] s, input logic c);
        exp_t e;
        model_val = model_val + int'(s[3:0]) + 10 * int'(s[7:4]) + 100 * int'(c);
        if (model_val > 9999) begin
            model_ovf = 1'b1;
            model_val = model_val - 10000;
        end
        e.total = to_bcd(model_val);
        e.ovf   = model_ovf;
        exp_q.push_back(e);
    endtask

    // Scoreboard: every out_valid pulse must match the oldest expected commit.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out_valid total=%h overflow=%b", total, overflow);
            end else begin
                e = exp_q.pop_front();
                if (total !== e.total || overflow !== e.ovf) begin
                    errors++;
                    $display("FAIL commit total=%h overflow=%b expected total=%h overflow=%b",
                             total, overflow, e.total, e.ovf);
                end
            end
        end
    end

    task automatic accept(input logic [7:0] s, input logic c);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_sum   = s;
        in_carry = c;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout in_ready=%b expected 1", in_ready);
        end
        @(posedge clk);
        if (s[3:0] <= 4'd9 && s[7:4] <= 4'd9) push_model(s, c);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !in_ready) && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; clear = 1'b0; in_sum = '0; in_carry = 1'b0;
        model_val = 0; model_ovf = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({total, overflow, out_valid, bad_digit, in_ready} !== {16'h0000, 4'b0001}) begin
            errors++;
            $display("FAIL reset_state total=%h ovf=%b ov=%b bad=%b rdy=%b expected 0000 0 0 0 1",
                     total, overflow, out_valid, bad_digit, in_ready);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic exp_ov;
        logic exp_rdy;
        @(negedge clk);
        in_valid = 1'b1; in_sum = 8'h05; in_carry = 1'b0;
        @(posedge clk);
        push_model(8'h05, 1'b0);
        #1 in_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            exp_ov  = (k == 5);
            exp_rdy = (k == 6);
            checks++;
            if (out_valid !== exp_ov || in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL timing_T+%0d out_valid=%b in_ready=%b expected %b %b",
                         k, out_valid, in_ready, exp_ov, exp_rdy);
            end
            if (k == 5) begin
                checks++;
                if (total !== 16'h0005) begin
                    errors++;
                    $display("FAIL basic_total total=%h expected 0005", total);
                end
            end
        end
    endtask

    task automatic test_carry();
        accept(8'h98, 1'b1);
        wait_drain();
        checks++;
        if (total !== 16'h0203 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL carry_198 total=%h overflow=%b expected 0203 0", total, overflow);
        end
    endtask

    task automatic test_overflow();
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        model_val = 0; model_ovf = 1'b0;
        checks++;
        if (total !== 16'h0000) begin
            errors++;
            $display("FAIL preload_clear total=%h expected 0000", total);
        end
        for (int i = 0; i < 50; i++) accept(8'h99, 1'b1);
        wait_drain();
        checks++;
        if (total !== 16'h9950 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL preload total=%h overflow=%b expected 9950 0", total, overflow);
        end
        accept(8'h99, 1'b1);
        wait_drain();
        checks++;
        if (total !== 16'h0149 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL wrap total=%h overflow=%b expected 0149 1", total, overflow);
        end
        accept(8'h01, 1'b0);
        wait_drain();
        checks++;
        if (total !== 16'h0150 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL sticky total=%h overflow=%b expected 0150 1", total, overflow);
        end
    endtask

    task automatic test_bad_digit();
        @(negedge clk);
        in_valid = 1'b1; in_sum = 8'h3A; in_carry = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({bad_digit, in_ready, out_valid} !== 3'b110 || total !== 16'h0150) begin
            errors++;
            $display("FAIL bad_digit_T+1 bad=%b rdy=%b ov=%b total=%h expected 1 1 0 0150",
                     bad_digit, in_ready, out_valid, total);
        end
        @(negedge clk);
        checks++;
        if (bad_digit !== 1'b0 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL bad_digit_pulse bad=%b overflow=%b expected 0 1", bad_digit, overflow);
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_clear();
        @(negedge clk);
        clear = 1'b1; in_valid = 1'b1; in_sum = 8'h05; in_carry = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL clear_ready in_ready=%b expected 0", in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0; clear = 1'b0;
        model_val = 0; model_ovf = 1'b0;
        @(negedge clk);
        checks++;
        if (total !== 16'h0000 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL clear total=%h overflow=%b expected 0000 0", total, overflow);
        end
        repeat (8) @(negedge clk);
        // Clear held across ADD cycles must be ignored; released before returning to IDLE.
        accept(8'h07, 1'b0);
        clear = 1'b1;
        repeat (2) @(negedge clk);
        clear = 1'b0;
        wait_drain();
        checks++;
        if (total !== 16'h0007) begin
            errors++;
            $display("FAIL clear_in_add total=%h expected 0007", total);
        end
    endtask

    task automatic test_reset_mid_add();
        int pulses;
        pulses = 0;
        accept(8'h07, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        exp_q.delete();
        model_val = 0; model_ovf = 1'b0;
        checks++;
        if ({total, in_ready, out_valid, overflow} !== {16'h0000, 3'b100}) begin
            errors++;
            $display("FAIL reset_mid_add total=%h rdy=%b ov=%b ovf=%b expected 0000 1 0 0",
                     total, in_ready, out_valid, overflow);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        checks++;
        if (pulses != 0 || total !== 16'h0000) begin
            errors++;
            $display("FAIL no_late_commit pulses=%0d total=%h expected 0 0000", pulses, total);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_overflow();
        test_bad_digit();
        test_clear();
        test_reset_mid_add();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_accumulator.md
# bcd_accumulator

Digit-serial BCD accumulator that sits directly downstream of the 8-bit two-digit BCD adder (`job_q_1`). It consumes each adder result through a valid/ready handshake: the 2-digit `Sum` plus `Carry_out` (hundreds digit), a value in the range 0–199. Each accepted result is added into a running multi-digit BCD total, one digit per clock, and completion is announced with a one-cycle pulse. The block also provides sticky overflow and invalid-digit indications.

## Interface
- `DIGITS`, default 4: number of BCD digits in the total; minimum 3.
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: upstream result available.
- `in_ready`  out  1: block can accept a result this cycle.
- `in_sum`  in  8: two BCD digits from the adder; `[3:0]` is units, `[7:4]` is tens.
- `in_carry`  in  1: adder carry-out, weighted as hundreds digit = 1.
- `clear`  in  1: synchronous clear of the total and flags; honoured only in IDLE.
- `total`  out  4*DIGITS: committed BCD total; digit *i* is at `[4i+3:4i]`.
- `out_valid`  out  1: one-cycle pulse when `total` has just been updated.
- `overflow`  out  1: sticky; set when the sum exceeds 10^DIGITS−1.
- `bad_digit`  out  1: one-cycle pulse when an accepted input had a nibble above 9.

## Operation
- Reset values: `total` = 0, `overflow` = 0, `out_valid` = 0, `bad_digit` = 0, `in_ready` = 1, state = IDLE.
- FSM states:
  - **IDLE:** `in_ready` = !`clear`. A handshake occurs when `in_valid` && `in_ready`.
  - **ADD:** runs for DIGITS cycles using an index `d` that counts 0..DIGITS−1.
  - **DONE:** lasts 1 cycle, then returns to IDLE.
- Handshake capture: `in_sum` and `in_carry` are captured into an addend register, and a working copy of `total` is taken.
- Addend digits are: digit0 = `in_sum[3:0]`, digit1 = `in_sum[7:4]`, digit2 = `in_carry`, and all higher digits = 0.
- Per ADD cycle:
  - work[d] = (work[d] + add[d] + c) mod 10.
  - c = 1 if the raw digit sum exceeds 9, else 0.
  - The digit carry `c` is cleared on entry to ADD.
- Final carry: if `c` = 1 after digit DIGITS−1, set `overflow`. The total wraps modulo 10^DIGITS.
- Commit: DONE copies work into `total` and pulses `out_valid`.
- Invalid input nibble (`in_sum[3:0]` > 9 or `in_sum[7:4]` > 9):
  - The handshake still completes and `bad_digit` pulses in the cycle after the handshake.
  - The FSM stays in IDLE; `total` and `overflow` are unchanged and `out_valid` does not pulse.
- `clear` in IDLE: the next cycle has `total` = 0 and `overflow` = 0. `clear` takes priority over a simultaneous `in_valid`; no handshake occurs because `in_ready` = 0.
- `clear` asserted during ADD or DONE is ignored. It is not latched, so upstream must hold it until IDLE.
- `rst` asserted mid-ADD: the in-flight addition is discarded, all outputs return to their reset values asynchronously, and `total` is never partially committed.

## Timing
- Handshake at edge T → ADD during cycles T+1..T+DIGITS → DONE at T+DIGITS+1.
- `out_valid` is high and `total` is updated in cycle T+DIGITS+1.
- `in_ready` is low from T+1 through T+DIGITS+1 and high again at T+DIGITS+2 (unless `clear` is asserted).
- Maximum throughput is one result per DIGITS+2 cycles; with DIGITS = 4, that is one per 6 cycles.
- `total` is stable between commits; intermediate work values are never visible on `total`.
- `overflow` rises in the same cycle as the `out_valid` that caused it.
- All outputs are registered; there is no combinational path from inputs to outputs except `clear` → `in_ready`.

## Structure
- Package `bcd_pkg` contains:
  - `BCD_W` = 4.
  - The state enum `bcd_acc_state_t` (IDLE, ADD, DONE).
  - The function `is_bcd(logic [3:0])`.
- Sub-module `bcd_digit_adder`: combinational; a 4-bit digit + 4-bit digit + carry in → 4-bit BCD digit + carry out (adds 6 when the raw sum exceeds 9). One instance is reused serially under index `d`.
- The top level holds the FSM, the digit index counter, the addend/work/total registers and the flags.

## Test plan
- Reset, then accept `in_sum` = 0x05, `in_carry` = 0 → at T+5, `out_valid` = 1 and `total` = 0x0005.
- Then accept `in_sum` = 0x98, `in_carry` = 1 (value 198) → `total` = 0x0203, `overflow` = 0.
- Preload via accumulation to `total` = 0x9950, then add 0x99 with carry 1 (199) → `total` = 0x0149, `overflow` = 1; `overflow` stays at 1 after a further add of 0x01.
- `in_sum` = 0x3A accepted → `bad_digit` pulses at T+1, `total` is unchanged, `out_valid` stays 0, and `in_ready` = 1 at T+1.
- `clear` and `in_valid` asserted together in IDLE → `in_ready` = 0 and no handshake; next cycle `total` = 0 and `overflow` = 0. `clear` pulsed during ADD has no effect.
- `rst` pulsed at T+2 during an add of 0x07 → `total` = 0, `in_ready` = 1 and `out_valid` = 0 immediately after reset; there is no later `out_valid` pulse.
